wavegen_dds: RTL and testbench
==============================

// Module: wavegen_dds
// PURPOSE
//   Parametrised phase-accumulator (DDS) waveform generator. Replaces the free-running fixed-8-bit generator.
//   Adds programmable frequency (tuning word), PWM duty, amplitude scaling and glitch-free mode/config
//   changes. Configuration is applied only at a period boundary. Feeds the DAC/PWM output stage of the lab top level.
// PARAMETERS
//   DATA_W   8   sample width; also the width of duty and amplitude
//   PHASE_W  16  phase accumulator width (must be >= DATA_W+1)
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        asynchronous, active-high reset
//   en         in   1        advance enable; low = freeze
//   cfg_valid  in   1        config offer
//   cfg_ready  out  1        config accept; handshake = cfg_valid & cfg_ready at a clk edge
//   cfg_mode   in   3        0 saw, 1 reverse saw, 2 triangle, 3 square, 4 PWM, 5-7 reserved (output 0)
//   cfg_ftw    in   PHASE_W  frequency tuning word (phase increment per enabled cycle)
//   cfg_duty   in   DATA_W   PWM threshold
//   cfg_amp    in   DATA_W   amplitude; 2^DATA_W-1 = full scale
//   out        out  DATA_W   registered sample
//   out_valid  out  1        out updated this cycle
//   wrap       out  1        1-cycle pulse; out holds the first sample of a new period
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, phase=0, active and shadow config=0, out=0, out_valid=0,
//     wrap=0, cfg_ready=1. Reset mid-operation discards any pending config.
//   Let p = phase[PHASE_W-1 -: DATA_W] and M = 2^DATA_W-1. Raw sample is combinational from the phase register:
//     saw = p; rsaw = ~p; tri = p[MSB] ? ~{p[DATA_W-2:0],0} : {p[DATA_W-2:0],0};
//     square = p[MSB] ? 0 : M; PWM = (p < duty) ? M : 0; reserved = 0.
//   Scaling: out <= (raw * (amp+1)) >> DATA_W, computed at 2*DATA_W+1 bits with no overflow.
//     amp=M gives raw exactly; amp=0 gives raw>>DATA_W = 0.
//   Latency: out at edge k+1 reflects the phase register value held before edge k+1 (1 cycle).
//   Phase: when en=1 and state is RUN or PENDING: phase <= phase + ftw mod 2^PHASE_W.
//     carry = carry-out of that add. wrap <= carry is registered, so it aligns with the first post-wrap sample.
//   en=0: phase, out and state hold; out_valid=0; wrap=0. Handshakes are still accepted per the FSM.
//   out_valid <= en & (state != IDLE).
//   FSM:
//     IDLE: cfg_ready=1. Handshake -> load active config, phase<=0, go to RUN. out stays 0, out_valid=0.
//     RUN: cfg_ready=1. Handshake -> capture shadow config, go to PENDING.
//     PENDING: cfg_ready=0.
//       - Same-cycle en & carry: active <= shadow; phase takes the wrapped value (no reset); go to RUN.
//         The new mode/amp applies from the first post-wrap sample.
//       - Active ftw==0 (no wrap possible): apply shadow on the next en cycle; phase<=0; go to RUN.
//   Simultaneous handshake and carry in RUN: the shadow is captured, but it applies at the NEXT wrap, not this one.
//   Handshake in the cycle PENDING->RUN is impossible (cfg_ready=0 in PENDING).
//   ftw >= 2^(PHASE_W-1) is legal; it aliases, and no special handling is applied.
// TESTING (DATA_W=8, PHASE_W=16)
//   1. Assert rst mid-run with a pending config -> same cycle: out=0, out_valid=0, wrap=0, cfg_ready=1;
//      after release, no output until a new handshake.
//   2. Handshake mode=0, ftw=0x0100, amp=255, en=1 -> out = 0,1,2,...,255,0,...;
//      wrap pulses with out=0 every 256 cycles; out_valid=1 throughout.
//   3. mode=3, ftw=0x0100, amp=127 -> 128 samples of 127, then 128 samples of 0, repeating.
//      amp=0 -> constant 0.
//   4. mode=4, duty=64, ftw=0x0200 -> 32 samples of 255, then 96 samples of 0 per period; duty=0 -> all 0.
//   5. Running saw with ftw=0x0100: at out=0x80, offer mode=2 -> cfg_ready=0.
//      Saw continues to 255. Then, with wrap=1: out=0, followed by 2,4,...,254,255,253,... (triangle).
//      cfg_ready=1 again after the switch.
//   6. en=0 for 10 cycles mid-saw at out=0x40 -> out holds 0x40, out_valid=0, no wrap; resume -> 0x41.
//      Also: PENDING with active ftw=0 -> shadow applied on the next en cycle.

Source files
------------

// File: rtl/wavegen_dds.sv
// Phase-accumulator (DDS) waveform generator.
// It provides saw, reverse saw, triangle, square and PWM waveforms with amplitude scaling.
// New configuration is accepted through a valid/ready handshake.
// A change offered while running takes effect only at the next period boundary,
// so the output never glitches mid-period.
module wavegen_dds #(
  parameter int DATA_W  = 8,
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2:0]         cfg_mode,
  input  logic [PHASE_W-1:0] cfg_ftw,
  input  logic [DATA_W-1:0]  cfg_duty,
  input  logic [DATA_W-1:0]  cfg_amp,
  output logic [DATA_W-1:0]  out,
  output logic               out_valid,
  output logic               wrap
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;

  localparam int PROD_W = 2 * DATA_W + 1;

  logic [1:0]         state_reg;
  logic [PHASE_W-1:0] phase_reg;
  logic               wrapped_reg;   // phase register holds the first phase of a new period

  // Active and shadow configuration
  logic [2:0]         act_mode_reg, sh_mode_reg;
  logic [PHASE_W-1:0] act_ftw_reg,  sh_ftw_reg;
  logic [DATA_W-1:0]  act_duty_reg, sh_duty_reg;
  logic [DATA_W-1:0]  act_amp_reg,  sh_amp_reg;

  logic               handshake;
  logic               advance;
  logic [PHASE_W:0]   phase_sum;
  logic               carry;
  logic [DATA_W-1:0]  p;
  logic [DATA_W-1:0]  tri_base;
  logic [DATA_W-1:0]  raw;
  logic [DATA_W:0]    amp_p1;
  logic [PROD_W-1:0]  prod;
  logic [DATA_W-1:0]  scaled;

  assign cfg_ready = (state_reg != PENDING);
  assign handshake = cfg_valid & cfg_ready;
  assign advance   = en & (state_reg != IDLE);
  assign phase_sum = {1'b0, phase_reg} + {1'b0, act_ftw_reg};
  assign carry     = phase_sum[PHASE_W];
  assign p         = phase_reg[PHASE_W-1 -: DATA_W];

  // The triangle ramp is the phase shifted left by one bit.
  // The top bit of the phase selects the rising or the falling half.
  assign tri_base[0] = 1'b0;
  for (genvar gi = 1; gi < DATA_W; gi++) begin : g_tri
    assign tri_base[gi] = p[gi-1];
  end

  // Raw waveform sample selected by the active mode
  always_comb begin
    raw = '0;
    case (act_mode_reg)
      3'd0:    raw = p;
      3'd1:    raw = ~p;
      3'd2:    raw = p[DATA_W-1] ? ~tri_base : tri_base;
      3'd3:    raw = p[DATA_W-1] ? '0 : '1;
      3'd4:    raw = (p < act_duty_reg) ? '1 : '0;
      default: raw = '0;
    endcase
  end

  // The amplitude scale factor is amp+1, so full-scale amp passes the raw sample through exactly.
  assign amp_p1 = {1'b0, act_amp_reg} + {{DATA_W{1'b0}}, 1'b1};
  assign prod   = {{(DATA_W+1){1'b0}}, raw} * {{DATA_W{1'b0}}, amp_p1};
  assign scaled = DATA_W'(prod >> DATA_W);

  // Control FSM: phase accumulation, configuration handshake and boundary-aligned switch-over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      phase_reg    <= '0;
      wrapped_reg  <= 1'b0;
      act_mode_reg <= '0;
      act_ftw_reg  <= '0;
      act_duty_reg <= '0;
      act_amp_reg  <= '0;
      sh_mode_reg  <= '0;
      sh_ftw_reg   <= '0;
      sh_duty_reg  <= '0;
      sh_amp_reg   <= '0;
    end else begin
      if (advance) begin
        phase_reg   <= phase_sum[PHASE_W-1:0];
        wrapped_reg <= carry;
      end
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            act_mode_reg <= cfg_mode;
            act_ftw_reg  <= cfg_ftw;
            act_duty_reg <= cfg_duty;
            act_amp_reg  <= cfg_amp;
            phase_reg    <= '0;
            wrapped_reg  <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          if (handshake) begin
            sh_mode_reg <= cfg_mode;
            sh_ftw_reg  <= cfg_ftw;
            sh_duty_reg <= cfg_duty;
            sh_amp_reg  <= cfg_amp;
            state_reg   <= PENDING;
          end
        end
        PENDING: begin
          if (en && (act_ftw_reg == '0 || carry)) begin
            act_mode_reg <= sh_mode_reg;
            act_ftw_reg  <= sh_ftw_reg;
            act_duty_reg <= sh_duty_reg;
            act_amp_reg  <= sh_amp_reg;
            state_reg    <= RUN;
            // A stalled accumulator can never wrap, so restart the period explicitly.
            if (act_ftw_reg == '0) phase_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Output register: one cycle behind the phase register; holds while frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      out_valid <= advance;
      wrap      <= advance & wrapped_reg;
      if (advance) out <= scaled;
    end
  end

endmodule

// File: tb/tb_wavegen_dds.sv
// Directed-vector bench for wavegen_dds (DATA_W=8, PHASE_W=16).
module tb_wavegen_dds;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_mode;
  logic [15:0] cfg_ftw;
  logic [7:0]  cfg_duty;
  logic [7:0]  cfg_amp;
  logic [7:0]  out;
  logic        out_valid;
  logic        wrap;

  int tests = 0;
  int fails = 0;

  wavegen_dds #(.DATA_W(8), .PHASE_W(16)) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_ftw(cfg_ftw), .cfg_duty(cfg_duty), .cfg_amp(cfg_amp),
    .out(out), .out_valid(out_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] ftw;
    logic [7:0]  duty;
    logic [7:0]  amp;
    int          idx;       // sample index after the starting handshake
    logic [7:0]  exp_out;
    logic        chk_wrap;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cfg_mode = '0; cfg_ftw = '0; cfg_duty = '0; cfg_amp = '0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic offer(input logic [2:0] m, input logic [15:0] f, input logic [7:0] d, input logic [7:0] a);
    cfg_mode = m; cfg_ftw = f; cfg_duty = d; cfg_amp = a;
    cfg_valid = 1'b1;
  endtask

  // Handshake from IDLE; afterwards sample i is visible after i+1 further steps.
  task automatic start(input logic [2:0] m, input logic [15:0] f, input logic [7:0] d, input logic [7:0] a);
    offer(m, f, d, a);
    en = 1'b1;
    step(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    // mode, ftw, duty, amp, idx, exp_out, chk_wrap, exp_wrap
    vecs.push_back(vec_t'{3'd0, 16'h0100, 8'd0,  8'd255, 0,   8'd0,   1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd0, 16'h0100, 8'd0,  8'd255, 5,   8'd5,   1'b1, 1'b0});
    vecs.push_back(vec_t'{3'd0, 16'h0100, 8'd0,  8'd255, 255, 8'd255, 1'b1, 1'b0});
    vecs.push_back(vec_t'{3'd0, 16'h0100, 8'd0,  8'd255, 256, 8'd0,   1'b1, 1'b1});
    vecs.push_back(vec_t'{3'd0, 16'h0100, 8'd0,  8'd255, 300, 8'd44,  1'b1, 1'b0});
    vecs.push_back(vec_t'{3'd1, 16'h0100, 8'd0,  8'd255, 3,   8'd252, 1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd2, 16'h0100, 8'd0,  8'd255, 1,   8'd2,   1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd2, 16'h0100, 8'd0,  8'd255, 127, 8'd254, 1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd2, 16'h0100, 8'd0,  8'd255, 128, 8'd255, 1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd2, 16'h0100, 8'd0,  8'd255, 129, 8'd253, 1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd3, 16'h0100, 8'd0,  8'd127, 0,   8'd127, 1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd3, 16'h0100, 8'd0,  8'd127, 127, 8'd127, 1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd3, 16'h0100, 8'd0,  8'd127, 128, 8'd0,   1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd3, 16'h0100, 8'd0,  8'd127, 256, 8'd127, 1'b1, 1'b1});
    vecs.push_back(vec_t'{3'd3, 16'h0100, 8'd0,  8'd0,   10,  8'd0,   1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd4, 16'h0200, 8'd64, 8'd255, 31,  8'd255, 1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd4, 16'h0200, 8'd64, 8'd255, 32,  8'd0,   1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd4, 16'h0200, 8'd64, 8'd255, 127, 8'd0,   1'b1, 1'b0});
    vecs.push_back(vec_t'{3'd4, 16'h0200, 8'd64, 8'd255, 128, 8'd255, 1'b1, 1'b1});
    vecs.push_back(vec_t'{3'd4, 16'h0200, 8'd0,  8'd255, 0,   8'd0,   1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd5, 16'h0100, 8'd0,  8'd255, 3,   8'd0,   1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd7, 16'h0100, 8'd0,  8'd255, 200, 8'd0,   1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd0, 16'h0100, 8'd0,  8'd127, 200, 8'd100, 1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd0, 16'h0100, 8'd0,  8'd0,   200, 8'd0,   1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd0, 16'h0080, 8'd0,  8'd255, 3,   8'd1,   1'b0, 1'b0});
    vecs.push_back(vec_t'{3'd0, 16'hFF00, 8'd0,  8'd255, 1,   8'd255, 1'b1, 1'b0});
    vecs.push_back(vec_t'{3'd0, 16'hFF00, 8'd0,  8'd255, 2,   8'd254, 1'b1, 1'b1});

    // Reset state
    do_reset();
    check("reset_out", out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_wrap", wrap, 0);
    check("reset_cfg_ready", cfg_ready, 1);

    // Table-driven vectors, each from a fresh reset
    foreach (vecs[i]) begin
      do_reset();
      start(vecs[i].mode, vecs[i].ftw, vecs[i].duty, vecs[i].amp);
      step(vecs[i].idx + 1);
      $display("[TB] vec %0d mode=%0d ftw=%h duty=%0d amp=%0d idx=%0d out=%0d exp=%0d wrap=%0d",
               i, vecs[i].mode, vecs[i].ftw, vecs[i].duty, vecs[i].amp, vecs[i].idx,
               out, vecs[i].exp_out, wrap);
      check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      if (vecs[i].chk_wrap) check($sformatf("vec%0d_wrap", i), wrap, vecs[i].exp_wrap);
    end

    // Saw to triangle switch at the period boundary
    do_reset();
    start(3'd0, 16'h0100, 8'd0, 8'd255);
    step(129);
    check("sw_at_80", out, 8'h80);
    offer(3'd2, 16'h0100, 8'd0, 8'd255);
    check("sw_ready_before", cfg_ready, 1);
    step(1);
    cfg_valid = 1'b0;
    check("sw_ready_pending", cfg_ready, 0);
    check("sw_still_saw", out, 8'h81);
    step(126);
    check("sw_last_saw", out, 255);
    step(1);
    $display("[TB] switch boundary out=%0d wrap=%0d ready=%0d", out, wrap, cfg_ready);
    check("sw_first_tri", out, 0);
    check("sw_wrap", wrap, 1);
    check("sw_ready_after", cfg_ready, 1);
    step(1);
    check("sw_tri_2", out, 2);
    step(1);
    check("sw_tri_4", out, 4);
    step(126);
    check("sw_tri_peak", out, 255);
    step(1);
    check("sw_tri_253", out, 253);

    // Handshake in the same cycle as a carry: applies at the following wrap
    do_reset();
    start(3'd0, 16'h0100, 8'd0, 8'd255);
    step(255);
    check("late_at_254", out, 254);
    offer(3'd2, 16'h0100, 8'd0, 8'd255);
    step(1);
    cfg_valid = 1'b0;
    check("late_255", out, 255);
    step(1);
    check("late_wrap_saw0", out, 0);
    step(1);
    check("late_still_saw", out, 1);
    step(255);
    check("late_next_wrap", wrap, 1);
    check("late_next_0", out, 0);
    step(1);
    check("late_now_tri", out, 2);

    // Freeze with en=0 mid-saw
    do_reset();
    start(3'd0, 16'h0100, 8'd0, 8'd255);
    step(65);
    check("frz_at_40", out, 8'h40);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check($sformatf("frz_out_%0d", k), out, 8'h40);
      check($sformatf("frz_valid_%0d", k), out_valid, 0);
      check($sformatf("frz_wrap_%0d", k), wrap, 0);
    end
    en = 1'b1;
    step(1);
    $display("[TB] freeze resume out=%0d valid=%0d", out, out_valid);
    check("frz_resume", out, 8'h41);
    check("frz_resume_valid", out_valid, 1);

    // PENDING with active ftw=0: shadow applied on the next enabled cycle
    do_reset();
    start(3'd0, 16'h0000, 8'd0, 8'd255);
    step(3);
    check("z_out_const", out, 0);
    en = 1'b0;
    offer(3'd0, 16'h0100, 8'd0, 8'd255);
    step(1);
    cfg_valid = 1'b0;
    check("z_pending", cfg_ready, 0);
    step(2);
    check("z_pending_frozen", cfg_ready, 0);
    en = 1'b1;
    step(1);
    check("z_applied_ready", cfg_ready, 1);
    step(2);
    check("z_new_saw_1", out, 1);
    step(1);
    check("z_new_saw_2", out, 2);

    // Asynchronous reset mid-run with a pending config
    do_reset();
    start(3'd0, 16'h0100, 8'd0, 8'd255);
    step(20);
    offer(3'd3, 16'h0100, 8'd0, 8'd127);
    step(1);
    cfg_valid = 1'b0;
    check("ar_pending", cfg_ready, 0);
    #3;
    rst = 1'b1;
    #1;
    $display("[TB] async reset out=%0d valid=%0d wrap=%0d ready=%0d", out, out_valid, wrap, cfg_ready);
    check("ar_out", out, 0);
    check("ar_valid", out_valid, 0);
    check("ar_wrap", wrap, 0);
    check("ar_ready", cfg_ready, 1);
    step(2);
    rst = 1'b0;
    step(5);
    check("ar_idle_out", out, 0);
    check("ar_idle_valid", out_valid, 0);
    start(3'd0, 16'h0100, 8'd0, 8'd255);
    step(4);
    check("ar_restart_saw", out, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
